pll_cfg_sequencer: RTL and testbench

//  Owns the video PLL's reconfiguration (mgmt) port and dynamic-phase port in the CLK_50M domain.

---
 rtl/pll_cfg_pkg.sv | 37 +++
 rtl/pll_cfg_sequencer_if.sv | 10 +
 rtl/pll_mgmt_writer.sv | 85 ++++++++
 rtl/pll_cfg_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_pll_cfg_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_cfg_pkg.sv
// rtl/pll_cfg_pkg.sv - shared state encodings, PLL mgmt register map and frequency selections
package pll_cfg_pkg;

  typedef enum logic [3:0] {
    WAIT_INIT,
    IDLE,
    W_MODE,
    W_FRAC,
    W_START,
    WAIT_UNLOCK,
    WAIT_LOCK,
    PH_EN,
    PH_WAIT,
    DONE_F,
    DONE_S
  } state_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ACTIVE,
    WR_GAP
  } wr_state_t;

  localparam logic [5:0] PLL_REG_MODE  = 6'd0;
  localparam logic [5:0] PLL_REG_START = 6'd2;
  localparam logic [5:0] PLL_REG_FRAC  = 6'd7;

  localparam logic [1:0] FREQ_VDC_NTSC = 2'd0;
  localparam logic [1:0] FREQ_VDC_PAL  = 2'd1;
  localparam logic [1:0] FREQ_VIC      = 2'd2;
  localparam logic [1:0] FREQ_VIC_ALT  = 2'd3;

  localparam logic [31:0] FRAC_VDC_NTSC_DEF = 32'd3357876127;
  localparam logic [31:0] FRAC_VDC_PAL_DEF  = 32'd1503512573;
  localparam logic [31:0] FRAC_VIC_DEF      = 32'd2233382994;

endpackage

// File: rtl/pll_cfg_sequencer_if.sv
// rtl/pll_cfg_sequencer_if.sv - PLL reconfiguration mgmt write bus
interface pll_cfg_sequencer_if;
  logic        cfg_write;
  logic [5:0]  cfg_address;
  logic [31:0] cfg_data;
  logic        cfg_waitrequest;

  modport master (output cfg_write, cfg_address, cfg_data, input cfg_waitrequest);
  modport slave  (input cfg_write, cfg_address, cfg_data, output cfg_waitrequest);
endinterface

// File: rtl/pll_mgmt_writer.sv
// rtl/pll_mgmt_writer.sv - one mgmt write held through waitrequest, then GAP_CYCLES idle cycles
// done pulses in the last gap cycle so a chained start lands with no extra bubble (GAP_CYCLES >= 1).
module pll_mgmt_writer
  import pll_cfg_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic        CLK_50M,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [5:0]  addr,
  input  logic [31:0] data,
  output logic        done,
  pll_cfg_sequencer_if.master cfg
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  wr_state_t   wr_state, wr_state_d;
  logic [GW-1:0] gap_cnt, gap_cnt_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;

  always_ff @(posedge CLK_50M) begin
    if (!reset_n) begin
      wr_state <= WR_IDLE;
      gap_cnt  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      wr_state <= wr_state_d;
      gap_cnt  <= gap_cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state;
    gap_cnt_d  = gap_cnt;
    addr_d     = addr_q;
    data_d     = data_q;
    done       = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (start) begin
          wr_state_d = WR_ACTIVE;
          addr_d     = addr;
          data_d     = data;
        end
      end
      WR_ACTIVE: begin
        if (!cfg.cfg_waitrequest) begin
          wr_state_d = WR_GAP;
          gap_cnt_d  = '0;
        end
      end
      WR_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          done = 1'b1;
          if (start) begin
            wr_state_d = WR_ACTIVE;
            addr_d     = addr;
            data_d     = data;
          end else begin
            wr_state_d = WR_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt + GW'(1);
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
    if (abort) begin
      wr_state_d = WR_IDLE;
    end
  end

  assign cfg.cfg_write   = (wr_state == WR_ACTIVE);
  assign cfg.cfg_address = addr_q;
  assign cfg.cfg_data    = data_q;

endmodule

// File: rtl/pll_cfg_sequencer.sv
// rtl/pll_cfg_sequencer.sv - arbitrates frequency reprogram and phase-step requests onto the video PLL
// Optional watchdog with sticky err: define PLL_CFG_TIMEOUT_EN.
module pll_cfg_sequencer
  import pll_cfg_pkg::*;
#(
  parameter logic [31:0] FRAC_VDC_NTSC = FRAC_VDC_NTSC_DEF,
  parameter logic [31:0] FRAC_VDC_PAL  = FRAC_VDC_PAL_DEF,
  parameter logic [31:0] FRAC_VIC      = FRAC_VIC_DEF,
  parameter int unsigned GAP_CYCLES    = 4
`ifdef PLL_CFG_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1048576
`endif
) (
  input  logic       CLK_50M,
  input  logic       reset_n,
  input  logic       freq_req,
  input  logic [1:0] freq_sel,
  output logic       freq_ack,
  input  logic       shift_req,
  input  logic       shift_updn,
  output logic       shift_ack,
  output logic       busy,
  pll_cfg_sequencer_if.master cfg,
  input  logic       pll_locked,
  output logic       pll_phase_en,
  output logic       pll_updn,
  input  logic       pll_phase_done,
  output logic       err
);

  state_t      state, state_d;
  logic [1:0]  sel_q, sel_d;
  logic        updn_q, updn_d;
  logic [3:0]  ph_cnt, ph_cnt_d;
  logic [5:0]  unl_cnt, unl_cnt_d;
  logic        locked_meta, locked_s, done_meta, done_s;
  logic        wr_start, wr_abort, wr_done;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;

  function automatic logic [31:0] frac_for(input logic [1:0] s);
    case (s)
      FREQ_VDC_NTSC: return FRAC_VDC_NTSC;
      FREQ_VDC_PAL:  return FRAC_VDC_PAL;
      default:       return FRAC_VIC;
    endcase
  endfunction

  always_ff @(posedge CLK_50M) begin
    if (!reset_n) begin
      state       <= WAIT_INIT;
      sel_q       <= '0;
      updn_q      <= 1'b0;
      ph_cnt      <= '0;
      unl_cnt     <= '0;
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
      done_meta   <= 1'b0;
      done_s      <= 1'b0;
    end else begin
      state       <= state_d;
      sel_q       <= sel_d;
      updn_q      <= updn_d;
      ph_cnt      <= ph_cnt_d;
      unl_cnt     <= unl_cnt_d;
      locked_meta <= pll_locked;
      locked_s    <= locked_meta;
      done_meta   <= pll_phase_done;
      done_s      <= done_meta;
    end
  end

`ifdef PLL_CFG_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic        to_run, to_hit, err_q;

  assign to_run = (state == WAIT_INIT) || (state == WAIT_LOCK) || (state == PH_EN) ||
                  (state == PH_WAIT) ||
                  (((state == W_MODE) || (state == W_FRAC) || (state == W_START)) && cfg.cfg_write);
  assign to_hit = to_run && (to_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK_50M) begin
    if (!reset_n) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_d != state) begin
        to_cnt <= '0;
      end else if (to_run) begin
        to_cnt <= to_cnt + 32'd1;
      end
      if (to_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d   = state;
    sel_d     = sel_q;
    updn_d    = updn_q;
    ph_cnt_d  = ph_cnt;
    unl_cnt_d = unl_cnt;
    wr_start  = 1'b0;
    wr_abort  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    // Each write is launched in the cycle that enters its state, so the writer's strobe lines up with it.
    case (state)
      WAIT_INIT: if (locked_s) state_d = IDLE;
      IDLE: begin
        if (!locked_s) begin
          state_d = WAIT_INIT;
        end else if (freq_req && !freq_ack) begin
          state_d  = W_MODE;
          sel_d    = freq_sel;
          wr_start = 1'b1;
          wr_addr  = PLL_REG_MODE;
        end else if (shift_req && !shift_ack) begin
          state_d  = PH_EN;
          updn_d   = shift_updn;
          ph_cnt_d = '0;
        end
      end
      W_MODE: begin
        if (wr_done) begin
          state_d  = W_FRAC;
          wr_start = 1'b1;
          wr_addr  = PLL_REG_FRAC;
          wr_data  = frac_for(sel_q);
        end
      end
      W_FRAC: begin
        if (wr_done) begin
          state_d  = W_START;
          wr_start = 1'b1;
          wr_addr  = PLL_REG_START;
        end
      end
      W_START: begin
        if (wr_done) begin
          state_d   = WAIT_UNLOCK;
          unl_cnt_d = '0;
        end
      end
      WAIT_UNLOCK: begin
        if (!locked_s || (unl_cnt == 6'd63)) state_d = WAIT_LOCK;
        else unl_cnt_d = unl_cnt + 6'd1;
      end
      WAIT_LOCK: if (locked_s) state_d = DONE_F;
      PH_EN: begin
        if (!done_s || (ph_cnt == 4'd15)) state_d = PH_WAIT;
        else ph_cnt_d = ph_cnt + 4'd1;
      end
      PH_WAIT: if (done_s) state_d = DONE_S;
      DONE_F:  if (!freq_req) state_d = IDLE;
      DONE_S:  if (!shift_req) state_d = IDLE;
      default: state_d = WAIT_INIT;
    endcase
`ifdef PLL_CFG_TIMEOUT_EN
    if (to_hit) begin
      wr_start = 1'b0;
      wr_abort = 1'b1;
      if (state == WAIT_INIT) state_d = IDLE;
      else if ((state == PH_EN) || (state == PH_WAIT)) state_d = DONE_S;
      else state_d = DONE_F;
    end
`endif
  end

  pll_mgmt_writer #(.GAP_CYCLES(GAP_CYCLES)) u_writer (
    .CLK_50M (CLK_50M),
    .reset_n (reset_n),
    .start   (wr_start),
    .abort   (wr_abort),
    .addr    (wr_addr),
    .data    (wr_data),
    .done    (wr_done),
    .cfg     (cfg)
  );

  assign freq_ack     = (state == DONE_F);
  assign shift_ack    = (state == DONE_S);
  assign pll_phase_en = (state == PH_EN);
  assign pll_updn     = updn_q;
  assign busy         = (state != IDLE) && (state != WAIT_INIT);

endmodule

// File: tb/tb_pll_cfg_sequencer.sv
// tb/tb_pll_cfg_sequencer.sv - randomized self-checking bench for pll_cfg_sequencer
module tb_pll_cfg_sequencer;

  localparam int GAP = 4;

  logic       CLK_50M;
  logic       reset_n;
  logic       freq_req;
  logic [1:0] freq_sel;
  logic       freq_ack;
  logic       shift_req;
  logic       shift_updn;
  logic       shift_ack;
  logic       busy;
  logic       pll_locked;
  logic       pll_phase_en;
  logic       pll_updn;
  logic       pll_phase_done;
  logic       err;

  pll_cfg_sequencer_if cfg ();

  pll_cfg_sequencer #(
    .GAP_CYCLES(GAP)
`ifdef PLL_CFG_TIMEOUT_EN
    , .TIMEOUT_CYCLES(100)
`endif
  ) dut (
    .CLK_50M        (CLK_50M),
    .reset_n        (reset_n),
    .freq_req       (freq_req),
    .freq_sel       (freq_sel),
    .freq_ack       (freq_ack),
    .shift_req      (shift_req),
    .shift_updn     (shift_updn),
    .shift_ack      (shift_ack),
    .busy           (busy),
    .cfg            (cfg),
    .pll_locked     (pll_locked),
    .pll_phase_en   (pll_phase_en),
    .pll_updn       (pll_updn),
    .pll_phase_done (pll_phase_done),
    .err            (err)
  );

  initial CLK_50M = 1'b0;
  always #10 CLK_50M = ~CLK_50M;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK_50M);
    #1;
  endtask

  function automatic logic [31:0] exp_frac(input int s);
    if (s == 0) return 32'd3357876127;
    if (s == 1) return 32'd1503512573;
    return 32'd2233382994;
  endfunction

  // PLL mgmt slave: per-write stall count chosen when the strobe rises.
  int max_stall = 0, force_frac = -1, cur_stall = 0, stall_left = 0;
  bit in_write = 0;
  always @(posedge CLK_50M) begin
    #1;
    if (cfg.cfg_write === 1'b1) begin
      if (!in_write) begin
        in_write   = 1;
        cur_stall  = (force_frac >= 0 && cfg.cfg_address == 6'd7) ? force_frac
                                                                    : int'($urandom_range(0, max_stall));
        stall_left = cur_stall;
      end
      cfg.cfg_waitrequest = (stall_left > 0);
      if (stall_left > 0) stall_left--;
    end else begin
      in_write = 0;
      cfg.cfg_waitrequest = 1'b0;
    end
  end

  // Bus monitor: accepted writes, hold stability, strobe length and inter-write gap.
  logic [5:0]  acc_a[$];
  logic [31:0] acc_d[$];
  logic        prev_w = 0;
  logic [5:0]  prev_a;
  logic [31:0] prev_d;
  int hold_len = 0, idle_cnt = 0;
  bit after_acc = 0;
  always @(negedge CLK_50M) begin
    if (!reset_n) begin
      prev_w = 0; after_acc = 0; hold_len = 0;
    end else begin
      if (cfg.cfg_write) begin
        if (!prev_w) begin
          hold_len = 0;
          if (after_acc) check_eq("gap_cycles", idle_cnt, GAP);
          after_acc = 0;
        end else begin
          check_eq("addr_hold", cfg.cfg_address, prev_a);
          check_eq("data_hold", cfg.cfg_data, prev_d);
        end
        hold_len++;
        if (!cfg.cfg_waitrequest) begin
          acc_a.push_back(cfg.cfg_address);
          acc_d.push_back(cfg.cfg_data);
          check_eq("write_len", hold_len, cur_stall + 1);
          after_acc = 1;
          idle_cnt  = 0;
        end
      end else if (after_acc) begin
        idle_cnt++;
      end
      if (freq_ack) after_acc = 0;
      prev_w = cfg.cfg_write;
      prev_a = cfg.cfg_address;
      prev_d = cfg.cfg_data;
    end
  end

  task automatic start_freq(input int s);
    freq_sel = 2'(s);
    freq_req = 1'b1;
    acc_a.delete();
    acc_d.delete();
  endtask

  task automatic start_shift(input logic u);
    shift_updn = u;
    shift_req  = 1'b1;
  endtask

  // mode 0: lock dips after the START write; mode 1: lock never drops.
  task automatic finish_freq(input int s, input int mode);
    int n, lat, ph;
    bit chg;
    logic [5:0]  ea[3];
    logic [31:0] ed[3];
    ea[0] = 6'd0; ea[1] = 6'd7; ea[2] = 6'd2;
    ed[0] = 32'd0; ed[1] = exp_frac(s); ed[2] = 32'd0;
    n = 0; ph = 0; chg = 0;
    while (acc_a.size() < 3 && n < 600) begin
      tick(); n++; ph += int'(pll_phase_en);
      if (acc_a.size() > 0 && !chg) begin
        freq_sel = 2'($urandom);
        chg = 1;
      end
    end
    check_eq("wr_count", acc_a.size(), 3);
    for (int i = 0; i < 3 && i < acc_a.size(); i++) begin
      check_eq("wr_addr", acc_a[i], ea[i]);
      check_eq("wr_data", acc_d[i], ed[i]);
    end
    lat = 0;
    if (mode == 0) begin
      pll_locked = 1'b0;
      repeat ($urandom_range(3, 8)) begin tick(); lat++; ph += int'(pll_phase_en); end
      pll_locked = 1'b1;
    end
    while (!freq_ack && lat < 300) begin tick(); lat++; ph += int'(pll_phase_en); end
    check_eq("freq_ack", freq_ack, 1);
    if (mode == 1) check_eq("unlock_wait", lat >= GAP + 64, 1);
    check_eq("busy_at_ack", busy, 1);
    check_eq("no_phase_in_freq", ph, 0);
    check_eq("wr_count_end", acc_a.size(), 3);
    freq_req = 1'b0;
    tick();
    check_eq("freq_ack_clr", freq_ack, 0);
    if (!shift_req) check_eq("busy_clr_f", busy, 0);
  endtask

  // stuck: phase_done never drops, so phase_en must stop after 16 cycles.
  task automatic finish_shift(input logic u, input bit stuck);
    int n, cnt;
    n = 0;
    while (!pll_phase_en && n < 60) begin tick(); n++; end
    check_eq("phase_en_seen", pll_phase_en, 1);
    check_eq("updn", pll_updn, u);
    shift_updn = ~u;
    if (!stuck) pll_phase_done = 1'b0;
    cnt = 0;
    while (pll_phase_en && cnt < 40) begin cnt++; tick(); end
    check_eq("phase_en_len", cnt, stuck ? 16 : 3);
    pll_phase_done = 1'b1;
    n = 0;
    while (!shift_ack && n < 60) begin tick(); n++; end
    check_eq("shift_ack", shift_ack, 1);
    check_eq("busy_at_sack", busy, 1);
    check_eq("updn_hold", pll_updn, u);
    shift_req = 1'b0;
    tick();
    check_eq("shift_ack_clr", shift_ack, 0);
    if (!freq_req) check_eq("busy_clr_s", busy, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int n, early;
    reset_n = 0; freq_req = 0; freq_sel = 0; shift_req = 0; shift_updn = 0;
    pll_locked = 0; pll_phase_done = 1; cfg.cfg_waitrequest = 0;
    repeat (3) tick();
    check_eq("rst_freq_ack", freq_ack, 0);
    check_eq("rst_shift_ack", shift_ack, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cfg_write", cfg.cfg_write, 0);
    check_eq("rst_cfg_addr", cfg.cfg_address, 0);
    check_eq("rst_cfg_data", cfg.cfg_data, 0);
    check_eq("rst_phase_en", pll_phase_en, 0);
    check_eq("rst_updn", pll_updn, 0);
    check_eq("rst_err", err, 0);

    // No grant before lock; lock arrives at cycle 10, sel=1, no stalls.
    reset_n = 1;
    start_freq(1);
    early = 0;
    repeat (9) begin tick(); early += int'(cfg.cfg_write | busy); end
    check_eq("no_grant_unlocked", early, 0);
    pll_locked = 1;
    finish_freq(1, 0);

    // FRAC write stalled 5 cycles.
    max_stall = 0; force_frac = 5;
    start_freq(0);
    finish_freq(0, 1);
    force_frac = -1;

    // Simultaneous requests: freq first, shift after freq handshake closes.
    start_freq(2);
    start_shift(1'b0);
    finish_freq(2, 0);
    finish_shift(1'b0, 0);

    start_shift(1'b1);
    finish_shift(1'b1, 0);

    start_shift(1'b0);
    finish_shift(1'b0, 1);

    // External unlock in IDLE: pending shift waits for lock.
    pll_locked = 0;
    repeat (4) tick();
    check_eq("unlock_idle_busy", busy, 0);
    start_shift(1'b1);
    early = 0;
    repeat (10) begin tick(); early += int'(pll_phase_en); end
    check_eq("no_shift_unlocked", early, 0);
    pll_locked = 1;
    finish_shift(1'b1, 0);

    // Reset mid-stall on the FRAC write.
    force_frac = 20;
    start_freq(3);
    n = 0;
    while (!(cfg.cfg_write && cfg.cfg_address == 6'd7 && cfg.cfg_waitrequest) && n < 200) begin
      tick(); n++;
    end
    check_eq("frac_stall_seen", cfg.cfg_write && cfg.cfg_address == 6'd7, 1);
    tick();
    reset_n = 0;
    tick();
    check_eq("rst_mid_write", cfg.cfg_write, 0);
    check_eq("rst_mid_fack", freq_ack, 0);
    check_eq("rst_mid_sack", shift_ack, 0);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_addr", cfg.cfg_address, 0);
    reset_n = 1;
    force_frac = -1;
    acc_a.delete();
    acc_d.delete();
    finish_freq(3, 0);

    for (int it = 0; it < 14; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        int s;
        s = int'($urandom_range(0, 3));
        max_stall = int'($urandom_range(0, 3));
        start_freq(s);
        finish_freq(s, int'($urandom_range(0, 1)));
      end else begin
        logic u;
        u = 1'($urandom);
        start_shift(u);
        finish_shift(u, $urandom_range(0, 3) == 0);
      end
    end
    max_stall = 0;

`ifdef PLL_CFG_TIMEOUT_EN
    start_freq(2);
    n = 0;
    while (acc_a.size() < 3 && n < 200) begin tick(); n++; end
    pll_locked = 0;
    n = 0;
    while (!freq_ack && n < 400) begin tick(); n++; end
    check_eq("to_freq_ack", freq_ack, 1);
    check_eq("to_err", err, 1);
    check_eq("to_latency", n >= 90 && n <= 130, 1);
    freq_req = 0;
    repeat (5) tick();
    check_eq("to_err_sticky", err, 1);
    pll_locked = 1;
`else
    check_eq("err_tied_low", err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
